// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI constants, FSM encoding and address helpers for the SRAM responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axi_sram_slave_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Numeric order matches severity for the responses this block can produce
    // (DECERR > SLVERR > OKAY), so "worst" is a plain max.
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_RD_REQ  = 6'b000010,
        ST_RD_WAIT = 6'b000100,
        ST_RD_DATA = 6'b001000,
        ST_WR_DATA = 6'b010000,
        ST_WR_RESP = 6'b100000
    } state_e;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    // WRAP is served as INCR (flagged SLVERR elsewhere); address wraps at 32 bits.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        if (burst == AXI_BURST_FIXED) return addr;
        return addr + (32'd1 << size);
    endfunction

    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle (AR/R/AW/W/B) between the CPU bridge and the SRAM responder.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on every channel.
// Ports: ar*/aw*/w* driven by master, r*/b* and the readys driven by slave.
interface axi_sram_slave_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [ID_WIDTH-1:0] wid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Burst address tracker: holds addr/len/size/burst and the beat count of the active burst.
// Latency: outputs reflect the current beat; load/advance take effect next cycle.
// Backpressure: none; caller pulses advance_i once per accepted beat.
// Ports: load_i + *_i latch a new burst; word_addr_o/last_o/range_err_o/burst_err_o describe the current beat.
module axi_burst_addr_gen
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load_i,
    input  logic [31:0]           addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] word_addr_o,
    output logic                  last_o,
    output logic                  range_err_o,
    output logic                  burst_err_o
);
    logic [31:0] addr_q,  addr_d;
    logic [7:0]  len_q,   len_d;
    logic [7:0]  beat_q,  beat_d;
    logic [2:0]  size_q,  size_d;
    logic [1:0]  burst_q, burst_d;

    always_comb begin
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        size_d  = size_q;
        burst_d = burst_q;
        if (load_i) begin
            addr_d  = addr_i;
            len_d   = len_i;
            beat_d  = 8'd0;
            size_d  = size_i;
            burst_d = burst_i;
        end else if (advance_i) begin
            addr_d  = next_addr(addr_q, size_q, burst_q);
            beat_d  = beat_q + 8'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    assign word_addr_o = addr_q[ADDR_WIDTH+1:2];
    assign last_o      = (beat_q == len_q);
    // Anything above the RAM's byte space decodes to nothing.
    assign range_err_o = (addr_q >> (ADDR_WIDTH + 2)) != 32'd0;
    assign burst_err_o = (burst_q == AXI_BURST_WRAP) || (size_q > 3'd2);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one transaction at a time from a single-port 1-cycle-latency SRAM.
// Latency: AR accept to first rvalid 3 cycles, 1 read beat per 3 cycles; writes 1 beat/cycle.
// Backpressure: R/B payload held until rready/bready; wready only while a write burst is open.
// Ports: aclk/aresetn (sync, active-low), axi (slave modport), ram_*_o to the SRAM, ram_rdata_i from it.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axi_sram_slave_if.slave       axi,
    output logic                  ram_en_o,
    output logic [3:0]            ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);
    state_e              state_q;
    grant_e              last_grant_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q;
    logic [1:0]          bresp_q;

    logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic ag_last, ag_range_err, ag_burst_err;
    logic [ADDR_WIDTH-1:0] ag_word_addr;
    logic [1:0] beat_resp, w_resp;

    // Round-robin on simultaneous AR/AW: the read wins only if the last grant was a write.
    assign axi.arready = aresetn && (state_q == ST_IDLE) && axi.arvalid &&
                         (!axi.awvalid || (last_grant_q == GRANT_WRITE));
    assign axi.awready = aresetn && (state_q == ST_IDLE) && axi.awvalid && !axi.arready;

    assign ar_hs = axi.arvalid && axi.arready;
    assign aw_hs = axi.awvalid && axi.awready;
    assign r_hs  = axi.rvalid  && axi.rready;
    assign w_hs  = axi.wvalid  && axi.wready;
    assign b_hs  = axi.bvalid  && axi.bready;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .load_i      (ar_hs || aw_hs),
        .addr_i      (ar_hs ? axi.araddr  : axi.awaddr),
        .len_i       (ar_hs ? axi.arlen   : axi.awlen),
        .size_i      (ar_hs ? axi.arsize  : axi.awsize),
        .burst_i     (ar_hs ? axi.arburst : axi.awburst),
        .advance_i   ((r_hs || w_hs) && !ag_last),
        .word_addr_o (ag_word_addr),
        .last_o      (ag_last),
        .range_err_o (ag_range_err),
        .burst_err_o (ag_burst_err)
    );

    assign beat_resp = ag_range_err ? AXI_RESP_DECERR :
                       ag_burst_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    // Burst length comes from awlen; a misplaced wlast only taints the response.
    assign w_resp = worst_resp(beat_resp,
                               (axi.wlast != ag_last) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);

    assign axi.rvalid = (state_q == ST_RD_DATA);
    assign axi.rid    = axi.rvalid ? id_q : '0;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;
    assign axi.rlast  = axi.rvalid && ag_last;
    assign axi.wready = (state_q == ST_WR_DATA);
    assign axi.bvalid = (state_q == ST_WR_RESP);
    assign axi.bid    = axi.bvalid ? id_q : '0;
    assign axi.bresp  = bresp_q;

    // Write beats hit the RAM in the same cycle as the W handshake.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 4'b0;
        ram_wdata_o = 32'd0;
        ram_addr_o  = ag_word_addr;
        if (state_q == ST_RD_REQ) begin
            ram_en_o = !ag_range_err;
        end else if ((state_q == ST_WR_DATA) && axi.wvalid && !ag_range_err) begin
            ram_en_o    = 1'b1;
            ram_we_o    = axi.wstrb;
            ram_wdata_o = axi.wdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_WRITE;
            id_q         <= '0;
            rdata_q      <= '0;
            rresp_q      <= AXI_RESP_OKAY;
            bresp_q      <= AXI_RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ar_hs) begin
                        id_q         <= axi.arid;
                        last_grant_q <= GRANT_READ;
                        state_q      <= ST_RD_REQ;
                    end else if (aw_hs) begin
                        id_q         <= axi.awid;
                        last_grant_q <= GRANT_WRITE;
                        bresp_q      <= AXI_RESP_OKAY;
                        state_q      <= ST_WR_DATA;
                    end
                end
                ST_RD_REQ: begin
                    rresp_q <= beat_resp;
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rdata_q <= ag_range_err ? 32'd0 : ram_rdata_i;
                    state_q <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (r_hs) state_q <= ag_last ? ST_IDLE : ST_RD_REQ;
                end
                ST_WR_DATA: begin
                    if (w_hs) begin
                        bresp_q <= worst_resp(bresp_q, w_resp);
                        if (ag_last) state_q <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic unused_sigs;
    assign unused_sigs = ^{axi.arlock, axi.arcache, axi.arprot,
                           axi.awlock, axi.awcache, axi.awprot, axi.wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural 1-cycle SRAM.
// Latency: n/a.
// Backpressure: bready held high; rready stalled on selected beats.
module tb_axi_sram_slave;
    localparam int AW = 16;
    localparam int IW = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_sram_slave_if #(.ID_WIDTH(IW)) axi ();

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    axi_sram_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .axi         (axi),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    logic [31:0] mem [0:(1<<AW)-1];
    int ram_en_cnt = 0;
    always @(posedge aclk) begin
        if (ram_en) begin
            ram_en_cnt <= ram_en_cnt + 1;
            if (ram_we == 4'b0) ram_rdata <= mem[ram_addr];
            else for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] exp_data [0:15];
    logic [31:0] wr_data  [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        n = 0;
        axi.arid = id; axi.araddr = addr; axi.arlen = len;
        axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        #1;
        while (!axi.arready && n < 20) begin step(); n++; end
        chk("ar_ready", axi.arready, 1);
        step();
        axi.arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        n = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len;
        axi.awsize = 3'd2; axi.awburst = 2'b01; axi.awvalid = 1'b1;
        #1;
        while (!axi.awready && n < 20) begin step(); n++; end
        chk("aw_ready", axi.awready, 1);
        step();
        axi.awvalid = 1'b0;
    endtask

    // Reads len+1 beats and compares them to exp_data; optional rready stall on one beat.
    task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] exp_resp, input int stall_beat, input int stall_n,
                           input bit send_ar, input bit chk_lat);
        int cyc;
        if (send_ar) ar_send(id, addr, len[7:0]);
        for (int i = 0; i <= len; i++) begin
            cyc = (i == 0) ? 1 : 0;
            axi.rready = (i != stall_beat);
            while (axi.rvalid !== 1'b1 && cyc < 40) begin step(); cyc++; end
            if (i == 0 && chk_lat) chk("r_latency", cyc, 3);
            chk("r_valid", axi.rvalid, 1);
            chk("r_data", axi.rdata, exp_data[i]);
            chk("r_id", axi.rid, id);
            chk("r_resp", axi.rresp, exp_resp);
            chk("r_last", axi.rlast, i == len);
            if (i == stall_beat) begin
                for (int k = 0; k < stall_n; k++) step();
                chk("stall_valid", axi.rvalid, 1);
                chk("stall_data", axi.rdata, exp_data[i]);
                chk("stall_last", axi.rlast, i == len);
                axi.rready = 1'b1;
            end
            step();
        end
        axi.rready = 1'b1;
    endtask

    // Writes len+1 beats from wr_data and checks each RAM strobe and the B response.
    task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                            input logic [3:0] strb, input bit bad_wlast,
                            input logic [1:0] exp_bresp, input bit send_aw);
        int n;
        if (send_aw) aw_send(id, addr, len[7:0]);
        for (int i = 0; i <= len; i++) begin
            axi.wdata = wr_data[i]; axi.wstrb = strb;
            axi.wlast = bad_wlast ? (i == 0) : (i == len);
            axi.wvalid = 1'b1;
            #1;
            n = 0;
            while (!axi.wready && n < 20) begin step(); n++; end
            chk("w_ready", axi.wready, 1);
            chk("w_ram_en", ram_en, 1);
            chk("w_ram_we", ram_we, strb);
            chk("w_ram_addr", ram_addr, ((addr >> 2) + i) & 32'hFFFF);
            chk("w_ram_wdata", ram_wdata, wr_data[i]);
            step();
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        n = 0;
        while (!axi.bvalid && n < 20) begin step(); n++; end
        chk("b_valid", axi.bvalid, 1);
        chk("b_id", axi.bid, id);
        chk("b_resp", axi.bresp, exp_bresp);
        step();
        chk("b_done", axi.bvalid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        int n;
        bit seen;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.arlock = '0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awlock = '0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.rready = 1'b1; axi.bready = 1'b1;

        // Reset: readys gated even with valids present.
        repeat (3) step();
        axi.arvalid = 1'b1; axi.awvalid = 1'b1;
        #1;
        chk("rst_arready", axi.arready, 0);
        chk("rst_awready", axi.awready, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_ram_en", ram_en, 0);
        axi.arvalid = 1'b0; axi.awvalid = 1'b0;
        aresetn = 1'b1;
        step();

        // Single write then readback.
        wr_data[0] = 32'hDEADBEEF;
        do_write(4'd1, 32'h100, 0, 4'hF, 1'b0, 2'b00, 1'b1);
        exp_data[0] = 32'hDEADBEEF;
        do_read(4'd0, 32'h100, 0, 2'b00, -1, 0, 1'b1, 1'b1);

        // 4-beat INCR with a 5-cycle rready stall on beat 2.
        for (int i = 0; i < 4; i++) begin
            wr_data[i]  = 32'hCAFE0080 + i;
            exp_data[i] = 32'hCAFE0080 + i;
        end
        do_write(4'd2, 32'h200, 3, 4'hF, 1'b0, 2'b00, 1'b1);
        do_read(4'd3, 32'h200, 3, 2'b00, 1, 5, 1'b1, 1'b0);

        // Byte-strobe merge.
        wr_data[0] = 32'h11223344;
        do_write(4'd1, 32'h300, 0, 4'hF, 1'b0, 2'b00, 1'b1);
        wr_data[0] = 32'h0000AB00;
        do_write(4'd1, 32'h300, 0, 4'b0010, 1'b0, 2'b00, 1'b1);
        exp_data[0] = 32'h1122AB44;
        do_read(4'd1, 32'h300, 0, 2'b00, -1, 0, 1'b1, 1'b0);

        // Out-of-range read: DECERR, zero data, RAM untouched.
        cnt0 = ram_en_cnt;
        exp_data[0] = 32'h0;
        do_read(4'd7, 32'h0004_0000, 0, 2'b11, -1, 0, 1'b1, 1'b0);
        chk("dec_ram_en_cnt", ram_en_cnt - cnt0, 0);

        // Misplaced wlast: both beats still written, SLVERR.
        wr_data[0] = 32'h55550000; wr_data[1] = 32'h55550001;
        do_write(4'd5, 32'h400, 1, 4'hF, 1'b1, 2'b10, 1'b1);
        exp_data[0] = 32'h55550000; exp_data[1] = 32'h55550001;
        do_read(4'd5, 32'h400, 1, 2'b00, -1, 0, 1'b1, 1'b0);

        // Arbitration: after reset read wins, after a read write wins.
        aresetn = 1'b0;
        step(); step();
        aresetn = 1'b1;
        axi.arid = 4'd3; axi.araddr = 32'h100; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'b01;
        axi.awid = 4'd4; axi.awaddr = 32'h500; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'b01;
        axi.arvalid = 1'b1; axi.awvalid = 1'b1;
        #1;
        chk("arb1_arready", axi.arready, 1);
        chk("arb1_awready", axi.awready, 0);
        step();
        axi.arvalid = 1'b0; axi.awvalid = 1'b0;
        exp_data[0] = 32'hDEADBEEF;
        do_read(4'd3, 32'h100, 0, 2'b00, -1, 0, 1'b0, 1'b0);
        axi.arvalid = 1'b1; axi.awvalid = 1'b1;
        #1;
        chk("arb2_arready", axi.arready, 0);
        chk("arb2_awready", axi.awready, 1);
        step();
        axi.arvalid = 1'b0; axi.awvalid = 1'b0;
        wr_data[0] = 32'h77777777;
        do_write(4'd4, 32'h500, 0, 4'hF, 1'b0, 2'b00, 1'b0);

        // Reset during beat 2 of a 4-beat read.
        ar_send(4'd5, 32'h200, 8'd3);
        axi.rready = 1'b1;
        n = 0;
        while (!axi.rvalid && n < 20) begin step(); n++; end
        step();
        axi.rready = 1'b0;
        n = 0;
        while (!axi.rvalid && n < 20) begin step(); n++; end
        chk("mid_beat2_data", axi.rdata, 32'hCAFE0081);
        aresetn = 1'b0;
        axi.arvalid = 1'b1; axi.awvalid = 1'b1;
        #1;
        chk("mid_rst_arready", axi.arready, 0);
        chk("mid_rst_awready", axi.awready, 0);
        step();
        chk("mid_rst_rvalid", axi.rvalid, 0);
        chk("mid_rst_wready", axi.wready, 0);
        chk("mid_rst_bvalid", axi.bvalid, 0);
        chk("mid_rst_ram_en", ram_en, 0);
        axi.arvalid = 1'b0; axi.awvalid = 1'b0;
        aresetn = 1'b1;
        axi.rready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            if (axi.rvalid || axi.bvalid) seen = 1'b1;
        end
        chk("no_resp_after_rst", seen, 0);
        exp_data[0] = 32'hDEADBEEF;
        do_read(4'd6, 32'h100, 0, 2'b00, -1, 0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
